matmul_sequencer: RTL and testbench
===================================

# matmul_sequencer

Sequencer that drives a single shared multiply-accumulate datapath through a full matrix product C = A × B, one MAC per cycle. It generates operand-memory read addresses, accumulates dot products in a 2-stage pipeline and emits result-memory writes. It sits between the Wishbone register front end, which supplies dimensions and start, and the A/B/C matrix storage arrays, replacing a combinational all-at-once multiplier.

## Interface
Parameters:
- DIM_BITS, 4: index width; maximum dimension 2^DIM_BITS.
- DATA_W, 32: operand width, signed two's complement.
- ACC_W, 32: accumulator and result width.

Ports:
- wb_clk_i  in  1  clock, all logic on rising edge.
- wb_rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  request a new product; sampled only in IDLE.
- abort_i  in  1  synchronous abort; highest priority after reset.
- dim_m_i, dim_k_i, dim_n_i  in  DIM_BITS+1 each  A is M×K, B is K×N; sampled with start_i.
- busy_o  out  1  high while a product is in progress.
- done_o  out  1  one-cycle pulse at completion, or on rejected start.
- err_o  out  1  level; set on rejected start, cleared by the next accepted start.
- rd_en_o  out  1  operand read strobe; memories return data exactly 1 cycle later.
- a_addr_o  out  2*DIM_BITS  {i,k}, row-major, stride 2^DIM_BITS.
- b_addr_o  out  2*DIM_BITS  {k,j}.
- a_data_i, b_data_i  in  DATA_W  read data, valid the cycle after rd_en_o.
- c_wr_en_o  out  1  result write strobe.
- c_addr_o  out  2*DIM_BITS  {i,j}.
- c_data_o  out  ACC_W  result value.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: if start_i is high and each dimension is in 1..2^DIM_BITS, latch the dimensions, clear i/j/k, clear err_o, go to RUN.
  - If any dimension is 0 or greater than 2^DIM_BITS: set err_o, pulse done_o, stay in IDLE, issue no reads.
- RUN: every cycle assert rd_en_o with the current addresses.
  - k increments; at K-1, k wraps to 0 and j increments.
  - At N-1, j wraps to 0 and i increments.
  - After the issue of (M-1, N-1, K-1), go to DRAIN.
- Pipeline stage 1 registers valid, first (k==0), last (k==K-1) and {i,j} alongside each read.
- Pipeline stage 2, when stage-1 valid: acc ← (first ? 0 : acc) + a_data_i × b_data_i.
  - The signed product is truncated to ACC_W and the sum wraps modulo 2^ACC_W.
  - If last, register c_wr_en_o=1, c_addr_o={i,j} and c_data_o=sum for one cycle.
- DRAIN: wait until the final write has been emitted, then pulse done_o and go to IDLE.
- start_i while busy is ignored; dimension inputs are ignored outside a start.
- abort_i: go to IDLE and flush pipeline valids.
  - No further rd_en_o or c_wr_en_o.
  - No done_o; err_o is unchanged.
  - An abort in IDLE has no effect.
- Reset: state IDLE, pipeline flushed. All outputs are 0, including busy_o, done_o, err_o, rd_en_o, c_wr_en_o, all addresses and c_data_o.

## Timing
- Start sampled at edge E0; rd_en_o is high for exactly P = M·N·K consecutive cycles starting the cycle after E0.
- No bubbles occur between dot products; throughput is 1 MAC per cycle.
- Each result write occurs 2 cycles after its last (k=K-1) read. Writes for consecutive (i,j) are spaced exactly K cycles apart.
- busy_o rises the cycle after E0 and falls in the cycle done_o pulses. done_o pulses 1 cycle after the final c_wr_en_o.
- Total: done_o is high in cycle P+3 after E0.
- A rejected start gives err_o and done_o in the cycle after E0; busy_o stays 0.
- A new start is accepted in the cycle following done_o.

## Test plan
- 1×1×1, A=3, B=-4:
  - rd_en_o high for 1 cycle.
  - c_wr_en_o 2 cycles later with addr 0 and data 0xFFFFFFF4.
  - done_o on the next cycle.
- 2×2×2, A=[[1,2],[3,4]], B=[[5,6],[7,8]]:
  - Writes C={i,j}: 00→19, 01→22, 10→43, 11→50, in that order, 2 cycles apart.
  - 8 reads total.
- dim_k_i=0 start:
  - err_o=1 and done_o pulses.
  - No rd_en_o and busy_o stays 0.
  - A following valid start clears err_o.
- Overflow, 1×1×2, A=[0x7FFFFFFF, 1], B=[2, 1]: C = 0xFFFFFFFF (wraps).
- Abort and ignored start:
  - Abort at read 5 of a 2×3×2 product: no writes after the abort cycle, no done_o, busy_o=0 next cycle.
  - start_i pulsed mid-run is ignored, with the read count unchanged.
- Maximum size 16×16×16 with back-to-back starts:
  - 4096 contiguous reads and 256 writes.
  - done_o at cycle 4099.
  - Second run starts cleanly.
  - Reset asserted mid-run zeroes all outputs asynchronously.

Source files
------------

// File: rtl/matmul_sequencer.sv
// Drives one shared MAC through C = A x B, one MAC per cycle, with a 2-stage
// read/accumulate pipeline feeding result-memory writes.
//
// state | meaning
// IDLE  | waiting for start; rejects out-of-range dimensions
// RUN   | issuing one operand read per cycle, k fastest, then j, then i
// DRAIN | reads finished, waiting for the final result write
module matmul_sequencer #(
  parameter int DIM_BITS = 4,
  parameter int DATA_W   = 32,
  parameter int ACC_W    = 32
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [DIM_BITS:0]     dim_m_i,
  input  logic [DIM_BITS:0]     dim_k_i,
  input  logic [DIM_BITS:0]     dim_n_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  rd_en_o,
  output logic [2*DIM_BITS-1:0] a_addr_o,
  output logic [2*DIM_BITS-1:0] b_addr_o,
  input  logic [DATA_W-1:0]     a_data_i,
  input  logic [DATA_W-1:0]     b_data_i,
  output logic                  c_wr_en_o,
  output logic [2*DIM_BITS-1:0] c_addr_o,
  output logic [ACC_W-1:0]      c_data_o
);

  localparam int AW = 2 * DIM_BITS;
  localparam logic [DIM_BITS:0] DIM_MAX = {1'b1, {DIM_BITS{1'b0}}};
  localparam logic [DIM_BITS:0] DIM_ONE = (DIM_BITS + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t r_state, w_state_nxt;

  logic [DIM_BITS-1:0] r_m_max, r_k_max, r_n_max;
  logic [DIM_BITS-1:0] r_i, r_j, r_k;

  logic          r_s1_valid, r_s1_first, r_s1_last;
  logic [AW-1:0] r_s1_addr;

  logic [ACC_W-1:0] r_acc, r_c_data;
  logic [AW-1:0]    r_c_addr;
  logic             r_c_wr_en, r_done, r_err;

  logic             w_dims_ok, w_accept, w_reject, w_drain_done, w_abort;
  logic             w_issue, w_k_wrap, w_j_wrap, w_last_issue;
  logic [ACC_W-1:0] w_prod, w_sum;

  assign w_dims_ok = (dim_m_i != '0) && (dim_m_i <= DIM_MAX) &&
                     (dim_k_i != '0) && (dim_k_i <= DIM_MAX) &&
                     (dim_n_i != '0) && (dim_n_i <= DIM_MAX);

  assign w_issue      = (r_state == S_RUN);
  assign w_abort      = abort_i && (r_state != S_IDLE);
  assign w_k_wrap     = (r_k == r_k_max);
  assign w_j_wrap     = (r_j == r_n_max);
  assign w_last_issue = w_k_wrap && w_j_wrap && (r_i == r_m_max);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_drain_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (w_dims_ok) begin
            w_accept    = 1'b1;
            w_state_nxt = S_RUN;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort_i)           w_state_nxt = S_IDLE;
        else if (w_last_issue) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // With K=1 writes arrive every cycle, so the final one is the write
        // that has no further dot product behind it in stage 1.
        if (abort_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_c_wr_en && !r_s1_valid) begin
          w_drain_done = 1'b1;
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_m_max <= '0;
      r_k_max <= '0;
      r_n_max <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
    end else if (w_accept) begin
      r_m_max <= DIM_BITS'(dim_m_i - DIM_ONE);
      r_k_max <= DIM_BITS'(dim_k_i - DIM_ONE);
      r_n_max <= DIM_BITS'(dim_n_i - DIM_ONE);
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
    end else if (w_issue && !abort_i) begin
      if (w_k_wrap) begin
        r_k <= '0;
        if (w_j_wrap) begin
          r_j <= '0;
          r_i <= r_i + 1'b1;
        end else begin
          r_j <= r_j + 1'b1;
        end
      end else begin
        r_k <= r_k + 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_addr  <= '0;
    end else if (w_abort) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_issue;
      r_s1_first <= (r_k == '0);
      r_s1_last  <= w_k_wrap;
      r_s1_addr  <= {r_i, r_j};
    end
  end

  // Low ACC_W bits of the product only depend on the operands, so the cast
  // gives the truncated signed product directly.
  assign w_prod = ACC_W'($signed(a_data_i) * $signed(b_data_i));
  assign w_sum  = (r_s1_first ? '0 : r_acc) + w_prod;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_acc     <= '0;
      r_c_wr_en <= 1'b0;
      r_c_addr  <= '0;
      r_c_data  <= '0;
    end else if (w_abort) begin
      r_c_wr_en <= 1'b0;
    end else begin
      r_c_wr_en <= r_s1_valid && r_s1_last;
      if (r_s1_valid) begin
        r_acc <= w_sum;
        if (r_s1_last) begin
          r_c_addr <= r_s1_addr;
          r_c_data <= w_sum;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_reject || w_drain_done;
      if (w_reject)      r_err <= 1'b1;
      else if (w_accept) r_err <= 1'b0;
    end
  end

  assign busy_o    = (r_state != S_IDLE);
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign rd_en_o   = w_issue;
  assign a_addr_o  = {r_i, r_k};
  assign b_addr_o  = {r_k, r_j};
  assign c_wr_en_o = r_c_wr_en;
  assign c_addr_o  = r_c_addr;
  assign c_data_o  = r_c_data;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: operand memories with one-cycle read
// latency, per-scenario tasks with hand-computed expectations.
module tb_matmul_sequencer;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [4:0]  dim_m_i = '0;
  logic [4:0]  dim_k_i = '0;
  logic [4:0]  dim_n_i = '0;
  logic        busy_o, done_o, err_o, rd_en_o, c_wr_en_o;
  logic [7:0]  a_addr_o, b_addr_o, c_addr_o;
  logic [31:0] a_data_i, b_data_i, c_data_o;

  matmul_sequencer dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start_i(start_i), .abort_i(abort_i),
    .dim_m_i(dim_m_i), .dim_k_i(dim_k_i), .dim_n_i(dim_n_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rd_en_o(rd_en_o),
    .a_addr_o(a_addr_o), .b_addr_o(b_addr_o), .a_data_i(a_data_i), .b_data_i(b_data_i),
    .c_wr_en_o(c_wr_en_o), .c_addr_o(c_addr_o), .c_data_o(c_data_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;

  // operand memories: read request seen in cycle c, data driven for cycle c+1
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic        rd_q = 1'b0;
  logic [7:0]  a_q = '0, b_q = '0;

  always @(negedge wb_clk_i) begin
    rd_q <= rd_en_o;
    a_q  <= a_addr_o;
    b_q  <= b_addr_o;
  end

  always @(posedge wb_clk_i) begin
    if (rd_q) begin
      a_data_i <= mem_a[a_q];
      b_data_i <= mem_b[b_q];
    end else begin
      a_data_i <= 'x;
      b_data_i <= 'x;
    end
  end

  // observations of the most recent run_op
  int         rd_cnt, first_rd, last_rd, done_rel, wr_cnt;
  logic       busy1, done1, err1, busy_after, busy_at_done;
  int         wr_rel [$];
  logic [7:0] wr_addr [$];
  logic [31:0] wr_data [$];

  task automatic clear_mem(input logic [31:0] v);
    for (int q = 0; q < 256; q++) begin
      mem_a[q] = v;
      mem_b[q] = v;
    end
  endtask

  task automatic load_2x2();
    clear_mem(32'd0);
    mem_a[8'h00] = 1; mem_a[8'h01] = 2; mem_a[8'h10] = 3; mem_a[8'h11] = 4;
    mem_b[8'h00] = 5; mem_b[8'h01] = 6; mem_b[8'h10] = 7; mem_b[8'h11] = 8;
  endtask

  // Starts a product at the current negedge and observes each following cycle.
  task automatic run_op(input int m, input int k, input int n, input int budget,
                        input int abort_at, input int mid_at, input int extra);
    int  abort_rel;
    bit  aborted;
    rd_cnt = 0; first_rd = 0; last_rd = 0; done_rel = 0;
    busy1 = 1'bx; done1 = 1'bx; err1 = 1'bx; busy_after = 1'bx; busy_at_done = 1'bx;
    wr_rel.delete(); wr_addr.delete(); wr_data.delete();
    aborted = 0; abort_rel = 0;
    dim_m_i = 5'(m); dim_k_i = 5'(k); dim_n_i = 5'(n);
    start_i = 1'b1;
    @(posedge wb_clk_i);
    for (int rel = 1; rel <= budget; rel++) begin
      @(negedge wb_clk_i);
      start_i = (rel == mid_at);
      if (rel == mid_at) begin
        dim_m_i = 5'd1; dim_k_i = 5'd1; dim_n_i = 5'd1;
      end
      abort_i = 1'b0;
      if (rel == 1) begin
        busy1 = busy_o; done1 = done_o; err1 = err_o;
      end
      if (rd_en_o) begin
        rd_cnt++;
        if (first_rd == 0) first_rd = rel;
        last_rd = rel;
      end
      if (c_wr_en_o) begin
        wr_rel.push_back(rel);
        wr_addr.push_back(c_addr_o);
        wr_data.push_back(c_data_o);
      end
      if (done_o && done_rel == 0) begin
        done_rel = rel;
        busy_at_done = busy_o;
      end
      if (aborted && rel == abort_rel + 1) busy_after = busy_o;
      if (abort_at != 0 && !aborted && rd_cnt == abort_at) begin
        abort_i = 1'b1;
        aborted = 1;
        abort_rel = rel;
      end
      if (done_rel != 0) break;
      if (aborted && rel >= abort_rel + extra) break;
    end
    start_i = 1'b0;
    abort_i = 1'b0;
    wr_cnt = wr_data.size();
    if (abort_at == 0) begin
      checks++;
      if (done_rel == 0) begin
        errors++;
        $display("FAIL run_timeout dims %0d/%0d/%0d: no done_o within %0d cycles", m, k, n, budget);
      end
    end
  endtask

  task automatic test_reset();
    logic [60:0] outs;
    #12;
    outs = {busy_o, done_o, err_o, rd_en_o, c_wr_en_o, a_addr_o, b_addr_o, c_addr_o, c_data_o};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", outs);
    end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    checks++;
    if ({busy_o, rd_en_o, done_o} !== 3'b000) begin
      errors++; $display("FAIL reset_idle got %b want 000", {busy_o, rd_en_o, done_o});
    end
  endtask

  task automatic test_single();
    clear_mem(32'd0);
    mem_a[0] = 32'd3;
    mem_b[0] = 32'hFFFF_FFFC;
    run_op(1, 1, 1, 50, 0, 0, 0);
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy1); end
    checks++;
    if (rd_cnt !== 1 || first_rd !== 1) begin
      errors++; $display("FAIL single_reads got cnt %0d first %0d want 1 1", rd_cnt, first_rd);
    end
    checks++;
    if (wr_cnt !== 1 || wr_rel[0] !== 3 || wr_addr[0] !== 8'h00 || wr_data[0] !== 32'hFFFF_FFF4) begin
      errors++;
      $display("FAIL single_write got cnt %0d cyc %0d addr %h data %h want 1 3 00 fffffff4",
               wr_cnt, wr_rel[0], wr_addr[0], wr_data[0]);
    end
    checks++;
    if (done_rel !== 4 || busy_at_done !== 1'b0) begin
      errors++; $display("FAIL single_done got cyc %0d busy %b want 4 0", done_rel, busy_at_done);
    end
    @(negedge wb_clk_i);
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL single_pulse got done %b busy %b want 0 0", done_o, busy_o);
    end
  endtask

  task automatic test_2x2(input int mid_at, input string tag);
    logic [7:0]  ea [4];
    logic [31:0] ed [4];
    ea = '{8'h00, 8'h01, 8'h10, 8'h11};
    ed = '{32'd19, 32'd22, 32'd43, 32'd50};
    load_2x2();
    run_op(2, 2, 2, 60, 0, mid_at, 0);
    checks++;
    if (rd_cnt !== 8 || first_rd !== 1 || last_rd !== 8) begin
      errors++;
      $display("FAIL %s_reads got cnt %0d first %0d last %0d want 8 1 8", tag, rd_cnt, first_rd, last_rd);
    end
    checks++;
    if (wr_cnt !== 4) begin errors++; $display("FAIL %s_wr_cnt got %0d want 4", tag, wr_cnt); end
    for (int q = 0; q < 4; q++) begin
      checks++;
      if (wr_addr[q] !== ea[q] || wr_data[q] !== ed[q] || wr_rel[q] !== 4 + 2 * q) begin
        errors++;
        $display("FAIL %s_write%0d got addr %h data %0d cyc %0d want %h %0d %0d",
                 tag, q, wr_addr[q], wr_data[q], wr_rel[q], ea[q], ed[q], 4 + 2 * q);
      end
    end
    checks++;
    if (done_rel !== 11) begin errors++; $display("FAIL %s_done got %0d want 11", tag, done_rel); end
  endtask

  task automatic test_reject();
    run_op(1, 0, 1, 10, 0, 0, 0);
    checks++;
    if (done_rel !== 1 || err1 !== 1'b1 || busy1 !== 1'b0 || rd_cnt !== 0) begin
      errors++;
      $display("FAIL reject_k0 got done %0d err %b busy %b reads %0d want 1 1 0 0",
               done_rel, err1, busy1, rd_cnt);
    end
    for (int q = 0; q < 4; q++) begin
      @(negedge wb_clk_i);
      checks++;
      if (rd_en_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b1 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL reject_hold got rd %b busy %b err %b done %b want 0 0 1 0",
                 rd_en_o, busy_o, err_o, done_o);
      end
    end
    run_op(17, 1, 1, 10, 0, 0, 0);
    checks++;
    if (done_rel !== 1 || err1 !== 1'b1 || busy1 !== 1'b0 || rd_cnt !== 0) begin
      errors++;
      $display("FAIL reject_m17 got done %0d err %b busy %b reads %0d want 1 1 0 0",
               done_rel, err1, busy1, rd_cnt);
    end
    load_2x2();
    run_op(1, 1, 1, 50, 0, 0, 0);
    checks++;
    if (err1 !== 1'b0 || wr_cnt !== 1 || wr_data[0] !== 32'd5 || done_rel !== 4) begin
      errors++;
      $display("FAIL reject_recover got err %b writes %0d data %0d done %0d want 0 1 5 4",
               err1, wr_cnt, wr_data[0], done_rel);
    end
  endtask

  task automatic test_overflow();
    clear_mem(32'd0);
    mem_a[8'h00] = 32'h7FFF_FFFF; mem_a[8'h01] = 32'd1;
    mem_b[8'h00] = 32'd2;         mem_b[8'h10] = 32'd1;
    run_op(1, 2, 1, 50, 0, 0, 0);
    checks++;
    if (wr_cnt !== 1 || wr_data[0] !== 32'hFFFF_FFFF || wr_addr[0] !== 8'h00 || wr_rel[0] !== 4) begin
      errors++;
      $display("FAIL overflow_write got cnt %0d data %h addr %h cyc %0d want 1 ffffffff 00 4",
               wr_cnt, wr_data[0], wr_addr[0], wr_rel[0]);
    end
    checks++;
    if (done_rel !== 5) begin errors++; $display("FAIL overflow_done got %0d want 5", done_rel); end
  endtask

  task automatic test_abort();
    load_2x2();
    // 2x3x2: C00 = 1*5 + 2*7 + 0*0 = 19, written in cycle 5 alongside read 5
    run_op(2, 3, 2, 60, 5, 0, 8);
    checks++;
    if (rd_cnt !== 5) begin errors++; $display("FAIL abort_reads got %0d want 5", rd_cnt); end
    checks++;
    if (wr_cnt !== 1 || wr_rel[0] !== 5 || wr_data[0] !== 32'd19) begin
      errors++;
      $display("FAIL abort_writes got cnt %0d cyc %0d data %0d want 1 5 19", wr_cnt, wr_rel[0], wr_data[0]);
    end
    checks++;
    if (done_rel !== 0 || busy_after !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got done %0d busy %b err %b want 0 0 0", done_rel, busy_after, err_o);
    end
  endtask

  task automatic test_back_to_back();
    int bad_data, bad_gap;
    clear_mem(32'd1);
    run_op(16, 16, 16, 4300, 0, 0, 0);
    checks++;
    if (rd_cnt !== 4096 || first_rd !== 1 || last_rd !== 4096) begin
      errors++;
      $display("FAIL max_reads got cnt %0d first %0d last %0d want 4096 1 4096", rd_cnt, first_rd, last_rd);
    end
    checks++;
    if (wr_cnt !== 256) begin errors++; $display("FAIL max_wr_cnt got %0d want 256", wr_cnt); end
    bad_data = 0; bad_gap = 0;
    for (int q = 0; q < wr_cnt; q++) begin
      if (wr_data[q] !== 32'd16 || wr_addr[q] !== 8'(q)) bad_data++;
      if (wr_rel[q] !== 18 + 16 * q) bad_gap++;
    end
    checks++;
    if (bad_data !== 0 || bad_gap !== 0) begin
      errors++; $display("FAIL max_writes got bad data %0d bad timing %0d want 0 0", bad_data, bad_gap);
    end
    checks++;
    if (done_rel !== 4099) begin errors++; $display("FAIL max_done got %0d want 4099", done_rel); end
    run_op(2, 2, 2, 60, 0, 0, 0);
    checks++;
    if (busy1 !== 1'b1 || rd_cnt !== 8 || first_rd !== 1 || done_rel !== 11 ||
        wr_cnt !== 4 || wr_data[3] !== 32'd2) begin
      errors++;
      $display("FAIL b2b_second got busy %b reads %0d first %0d done %0d writes %0d want 1 8 1 11 4",
               busy1, rd_cnt, first_rd, done_rel, wr_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    logic [60:0] outs;
    clear_mem(32'd1);
    dim_m_i = 5'd16; dim_k_i = 5'd16; dim_n_i = 5'd16;
    start_i = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    start_i = 1'b0;
    repeat (100) @(negedge wb_clk_i);
    checks++;
    if (busy_o !== 1'b1 || rd_en_o !== 1'b1) begin
      errors++; $display("FAIL midrun_active got busy %b rd %b want 1 1", busy_o, rd_en_o);
    end
    #2;
    wb_rst_i = 1'b0;
    #1;
    outs = {busy_o, done_o, err_o, rd_en_o, c_wr_en_o, a_addr_o, b_addr_o, c_addr_o, c_data_o};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL midrun_reset got %h want 0", outs); end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    checks++;
    if (busy_o !== 1'b0 || rd_en_o !== 1'b0 || c_wr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL midrun_after got busy %b rd %b wr %b want 0 0 0", busy_o, rd_en_o, c_wr_en_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_2x2(0, "mm2");
    test_reject();
    test_overflow();
    test_2x2(3, "ignstart");
    test_abort();
    @(negedge wb_clk_i);
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
